lt16_soc_top: RTL and testbench

- Minimal SoC top-level control block for the lt16soc board build.
- Synchronises board inputs: 2 buttons, 8 switches and 2 test interrupt lines.
- Keeps interrupt pending and event-count state, plus a heartbeat timer.
- Drives 8 LEDs from a switch-selected status view; no CPU or bus inside this block.

---
 rtl/lt16_soc_top.sv | 121 ++++++++++++
 tb/tb_lt16_soc_top.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lt16_soc_top.sv
// lt16soc board control block: input synchronisers, test-IRQ event counters,
// pending flag, heartbeat timer and a switch-selected LED status view.

module lt16_irq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_rise,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // A clear coinciding with a rise keeps that rise as the first new count.
  always_ff @(posedge clk) begin
    if (!rst)        r_cnt <= '0;
    else if (i_clr)  r_cnt <= W'(i_rise);
    else if (i_rise) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

module lt16_soc_top #(
  parameter logic RST_ACTIVE_HIGH  = 1'b0,
  parameter int   HEARTBEAT_CYCLES = 1000
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic [1:0] btn,
  input  logic [7:0] sw,
  input  logic       test_irq0,
  input  logic       test_irq1,
  output logic [7:0] led
);
  localparam int          NUM_IRQ = 2;
  localparam int          IN_W    = 8 + 2 + NUM_IRQ;
  localparam logic [23:0] HB_LAST = 24'(HEARTBEAT_CYCLES - 1);

  logic [IN_W-1:0]              r_meta, r_sync;
  logic [3:0]                   r_prev;
  logic [3:0]                   w_rise;
  logic [7:0]                   w_s_sw;
  logic [NUM_IRQ-1:0][7:0]      w_irq_cnt;
  logic                         r_pend;
  logic [23:0]                  r_hb_cnt;
  logic                         r_hb;
  logic [7:0]                   r_up_cnt;
  logic                         w_hb_wrap;
  logic [5:0]                   w_view;
  logic                         w_unused;

  // Packed as {irq1, irq0, btn[1:0], sw[7:0]} so edge bits sit on top.
  always_ff @(posedge clk_sys) begin
    if (!rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= {test_irq1, test_irq0, btn, sw};
      r_sync <= r_meta;
      r_prev <= r_sync[IN_W-1:8];
    end
  end

  assign w_s_sw = r_sync[7:0];
  // w_rise = {irq1, irq0, btn1, btn0}
  assign w_rise = r_sync[IN_W-1:8] & ~r_prev;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq
    lt16_irq_cnt #(.W(8)) u_cnt (
      .clk    (clk_sys),
      .rst    (rst),
      .i_rise (w_rise[2+i]),
      .i_clr  (w_rise[1]),
      .o_cnt  (w_irq_cnt[i])
    );
  end

  always_ff @(posedge clk_sys) begin
    if (!rst)              r_pend <= 1'b0;
    else if (|w_rise[3:2]) r_pend <= 1'b1;
    else if (w_rise[0])    r_pend <= 1'b0;
  end

  assign w_hb_wrap = (r_hb_cnt == HB_LAST);

  always_ff @(posedge clk_sys) begin
    if (!rst) begin
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
      r_up_cnt <= '0;
    end else if (w_hb_wrap) begin
      r_hb_cnt <= '0;
      r_hb     <= ~r_hb;
      r_up_cnt <= r_up_cnt + 1'b1;
    end else begin
      r_hb_cnt <= r_hb_cnt + 1'b1;
    end
  end

  always_comb begin
    w_view = w_s_sw[5:0];
    case (w_s_sw[7:6])
      2'b01:   w_view = w_irq_cnt[0][5:0];
      2'b10:   w_view = w_irq_cnt[1][5:0];
      2'b11:   w_view = r_up_cnt[5:0];
      default: w_view = w_s_sw[5:0];
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst) led <= '0;
    else      led <= {r_hb, r_pend, w_view};
  end

  // Legacy polarity parameter and counter tops never reach the LEDs.
  assign w_unused = ^{RST_ACTIVE_HIGH, w_irq_cnt[0][7:6], w_irq_cnt[1][7:6],
                      r_up_cnt[7:6]};
endmodule

// File: tb/tb_lt16_soc_top.sv
// Bench for lt16_soc_top: directed vector table, wrap/heartbeat sequences and
// randomized stimulus, all checked against a sample-history reference model.

module tb_lt16_soc_top;
  localparam int N = 10;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] btn = '0;
  logic [7:0] sw = '0;
  logic       test_irq0 = 1'b0;
  logic       test_irq1 = 1'b0;
  wire  [7:0] led;

  lt16_soc_top #(.RST_ACTIVE_HIGH(1'b0), .HEARTBEAT_CYCLES(N)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .btn       (btn),
    .sw        (sw),
    .test_irq0 (test_irq0),
    .test_irq1 (test_irq1),
    .led       (led)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  // Reference model: history of values sampled at each edge ([0] = newest),
  // plus event counts derived from that history.
  logic [7:0] h_sw [4];
  logic [1:0] h_btn[4];
  logic       h_i0 [4];
  logic       h_i1 [4];
  int         m_k;
  int         m_c0, m_c1;
  bit         m_pend;
  logic [7:0] m_led;
  int         toggles;
  logic       last7;

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp, input logic [7:0] msk);
    total++;
    if ((act & msk) !== (exp & msk)) begin
      bad++;
      $display("FAIL %s: led=%h expected %h (mask %h) at %0t", nm, act, exp, msk, $time);
    end
  endtask

  task automatic model_edge();
    int  wraps;
    logic [5:0] v;
    bit r0, r1, b0, b1;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        h_sw[i] = '0; h_btn[i] = '0; h_i0[i] = 1'b0; h_i1[i] = 1'b0;
      end
      m_k = 0; m_c0 = 0; m_c1 = 0; m_pend = 1'b0; m_led = '0;
    end else begin
      for (int i = 3; i > 0; i--) begin
        h_sw[i] = h_sw[i-1]; h_btn[i] = h_btn[i-1];
        h_i0[i] = h_i0[i-1]; h_i1[i] = h_i1[i-1];
      end
      h_sw[0] = sw; h_btn[0] = btn; h_i0[0] = test_irq0; h_i1[0] = test_irq1;
      m_k++;
      // LED shows state as it was before this edge; heartbeat wraps every N edges.
      wraps = (m_k - 1) / N;
      case (h_sw[2][7:6])
        2'b00:   v = h_sw[2][5:0];
        2'b01:   v = 6'(m_c0);
        2'b10:   v = 6'(m_c1);
        default: v = 6'(wraps % 256);
      endcase
      m_led = {1'(wraps % 2), m_pend, v};
      r0 = h_i0[2] && !h_i0[3];
      r1 = h_i1[2] && !h_i1[3];
      b0 = h_btn[2][0] && !h_btn[3][0];
      b1 = h_btn[2][1] && !h_btn[3][1];
      if (b1) begin
        m_c0 = r0 ? 1 : 0;
        m_c1 = r1 ? 1 : 0;
      end else begin
        if (r0) m_c0 = (m_c0 + 1) % 256;
        if (r1) m_c1 = (m_c1 + 1) % 256;
      end
      if (r0 || r1) m_pend = 1'b1;
      else if (b0)  m_pend = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
    check("model", led, m_led, 8'hFF);
    if (led[7] !== last7) toggles++;
    last7 = led[7];
  endtask

  typedef struct {
    string      name;
    logic [7:0] sw;
    logic [1:0] btn;
    logic       i0;
    logic       i1;
    int         cyc;
    logic [7:0] exp;
    logic [7:0] msk;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{"rst_hold",     8'h00, 2'b00, 1'b0, 1'b0, 5, 8'h00, 8'hFF};
    vecs[1]  = '{"hb_first",     8'h00, 2'b00, 1'b0, 1'b0, 6, 8'h80, 8'hFF};
    vecs[2]  = '{"sw_mirror",    8'h2D, 2'b00, 1'b0, 1'b0, 3, 8'h2D, 8'h7F};
    vecs[3]  = '{"view_irq1",    8'hAA, 2'b00, 1'b0, 1'b0, 3, 8'h00, 8'h7F};
    vecs[4]  = '{"view_irq0",    8'h55, 2'b00, 1'b0, 1'b0, 3, 8'h00, 8'h7F};
    vecs[5]  = '{"irq0_rise",    8'h55, 2'b00, 1'b1, 1'b0, 4, 8'h41, 8'h7F};
    vecs[6]  = '{"irq0_held",    8'h55, 2'b00, 1'b1, 1'b0, 6, 8'h41, 8'h7F};
    vecs[7]  = '{"irq0_low",     8'h55, 2'b00, 1'b0, 1'b0, 4, 8'h41, 8'h7F};
    vecs[8]  = '{"btn0_early",   8'h55, 2'b01, 1'b0, 1'b0, 3, 8'h41, 8'h7F};
    vecs[9]  = '{"btn0_clr",     8'h55, 2'b00, 1'b0, 1'b0, 2, 8'h01, 8'h7F};
    vecs[10] = '{"btn1_clr",     8'h55, 2'b10, 1'b0, 1'b0, 4, 8'h00, 8'h7F};
    vecs[11] = '{"btn1_rel",     8'h55, 2'b00, 1'b0, 1'b0, 1, 8'h00, 8'h7F};
    vecs[12] = '{"irq1_btn1",    8'hAA, 2'b10, 1'b0, 1'b1, 4, 8'h41, 8'h7F};
    vecs[13] = '{"irq1_btn1_rel",8'hAA, 2'b00, 1'b0, 1'b0, 4, 8'h41, 8'h7F};

    toggles = 0;
    last7   = 1'b0;

    rst = 1'b0;
    tick();
    check("reset", led, 8'h00, 8'hFF);
    rst = 1'b1;

    foreach (vecs[i]) begin
      sw = vecs[i].sw; btn = vecs[i].btn;
      test_irq0 = vecs[i].i0; test_irq1 = vecs[i].i1;
      repeat (vecs[i].cyc) tick();
      check(vecs[i].name, led, vecs[i].exp, vecs[i].msk);
    end

    // 8-bit wrap of irq0_cnt: 255 shows 6'h3F, the 256th pulse returns to 0.
    sw = 8'h55;
    for (int p = 1; p <= 256; p++) begin
      test_irq0 = 1'b1; repeat (2) tick();
      test_irq0 = 1'b0; repeat (2) tick();
      if (p == 255) check("irq0_cnt_255", led, 8'h7F, 8'h7F);
    end
    check("irq0_cnt_wrap", led, 8'h40, 8'h7F);

    // Mid-run reset, then 10 heartbeat periods viewed through up_cnt.
    rst = 1'b0; sw = 8'hC0;
    tick();
    check("reset_mid", led, 8'h00, 8'hFF);
    rst = 1'b1;
    toggles = 0;
    last7 = led[7];
    repeat (10 * N + 1) tick();
    check("up_cnt_10", led, 8'h0A, 8'hFF);
    total++;
    if (toggles != 10) begin
      bad++;
      $display("FAIL hb_toggles: got %0d expected 10", toggles);
    end

    // Random traffic including single-cycle pulses and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) sw = 8'($urandom);
      if ($urandom_range(9) == 0) btn[0] = ~btn[0];
      if ($urandom_range(15) == 0) btn[1] = ~btn[1];
      if ($urandom_range(3) == 0) test_irq0 = ~test_irq0;
      if ($urandom_range(4) == 0) test_irq1 = ~test_irq1;
      rst = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
